// File: rtl/clint_pkg.sv
// Shared CLINT definitions: bus width, register map offsets, FSM/decode enums
// and the byte-merge helper used by every writable register.
package clint_pkg;

  localparam int DATA_BUS_SIZE = 64;
  typedef logic [DATA_BUS_SIZE-1:0] DATA_BUS;

  localparam DATA_BUS CLINT_BASE         = 64'h0000_0000_0200_0000;
  localparam DATA_BUS CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
  localparam DATA_BUS CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam DATA_BUS CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } clint_state_e;

  typedef enum logic [1:0] {
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME,
    SEL_NONE
  } clint_sel_e;

  function automatic DATA_BUS wmerge(input DATA_BUS old, input DATA_BUS wdata,
                                     input logic [7:0] wmask);
    DATA_BUS res;
    for (int i = 0; i < 8; i++)
      res[i*8 +: 8] = wmask[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Prescaler, mtime/mtimecmp registers and the registered timer-interrupt flag.
module clint_timer
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mtime_we,
  input  logic       mtimecmp_we,
  input  DATA_BUS    wdata,
  input  logic [7:0] wmask,
  output DATA_BUS    mtime,
  output DATA_BUS    mtimecmp,
  output logic       mtip
);

  localparam int CW = 16;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TC);

  always_ff @(posedge clk) begin
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
  end

  // A software write to mtime takes priority; the coincident tick is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      mtip     <= 1'b0;
    end else begin
      if (mtime_we)  mtime <= wmerge(mtime, wdata, wmask);
      else if (tick) mtime <= mtime + 64'd1;
      if (mtimecmp_we) mtimecmp <= wmerge(mtimecmp, wdata, wmask);
      mtip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/clint_top.sv
// Core-local interruptor: request FSM, address decode and response registers.
// Optional msip register enabled by defining CLINT_MSIP_EN.
//
// state   | meaning
// ST_IDLE | req_ready=1, waiting for a request
// ST_RESP | rsp_valid=1, holding response until rsp_ready
module clint_top
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = CLINT_BASE,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        clint_mtip,
  output logic        clint_msip
);

  clint_state_e state;
  clint_sel_e   sel;
  DATA_BUS      addr_dw;
  DATA_BUS      rd_data;
  DATA_BUS      mtime;
  DATA_BUS      mtimecmp;
  logic         accept_wr;
  logic         msip_bit;

  assign addr_dw   = {req_addr[63:3], 3'b000};
  assign accept_wr = req_valid & req_ready & req_wen;

  always_comb begin
    sel = SEL_NONE;
    if (addr_dw == BASE_ADDR + CLINT_MTIMECMP_OFF)   sel = SEL_MTIMECMP;
    else if (addr_dw == BASE_ADDR + CLINT_MTIME_OFF) sel = SEL_MTIME;
`ifdef CLINT_MSIP_EN
    else if (addr_dw == BASE_ADDR + CLINT_MSIP_OFF)  sel = SEL_MSIP;
`endif
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_MSIP:     rd_data = {63'b0, msip_bit};
      SEL_MTIMECMP: rd_data = mtimecmp;
      SEL_MTIME:    rd_data = mtime;
      default:      rd_data = '0;
    endcase
  end

  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .mtime_we   (accept_wr && (sel == SEL_MTIME)),
    .mtimecmp_we(accept_wr && (sel == SEL_MTIMECMP)),
    .wdata      (req_wdata),
    .wmask      (req_wmask),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .mtip       (clint_mtip)
  );

`ifdef CLINT_MSIP_EN
  logic msip_q;
  always_ff @(posedge clk) begin
    if (rst) msip_q <= 1'b0;
    else if (accept_wr && (sel == SEL_MSIP) && req_wmask[0]) msip_q <= req_wdata[0];
  end
  assign msip_bit = msip_q;
`else
  assign msip_bit = 1'b0;
`endif

  assign clint_msip = msip_bit;

  // Reads capture the pre-edge register value, so a same-cycle tick is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          state     <= ST_RESP;
          req_ready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= req_wen ? '0 : rd_data;
          rsp_err   <= (sel == SEL_NONE);
        end
        ST_RESP: if (rsp_ready) begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_top.sv
// Bench for clint_top: two instances (TICK_DIV 4 and 1) share one request bus
// and are checked against an arithmetic model of mtime, mtimecmp and msip.
module tb_clint_top;

  localparam logic [63:0] BASE  = 64'h0000_0000_0200_0000;
  localparam longint unsigned DIV_A = 4;
  localparam longint unsigned DIV_B = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic        mtip      [2];
  logic        msip      [2];
  logic [63:0] rsp_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mtime = base_val + ticks since the last mtime write.
  longint unsigned k;
  logic [63:0]     base_val   [2];
  longint unsigned base_ticks [2];
  logic [63:0]     cmp_m      [2];
  logic            msip_m;

  always #5 clk = ~clk;

  always @(posedge clk) k <= rst ? 0 : k + 1;

  clint_top #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .clint_mtip(mtip[0]), .clint_msip(msip[0])
  );

  clint_top #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .clint_mtip(mtip[1]), .clint_msip(msip[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned div_of(input int d);
    return (d == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic logic [63:0] mt(input int d, input longint unsigned kk);
    return base_val[d] + (kk / div_of(d) - base_ticks[d]);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] wm);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = wm[i/8] ? wd[i] : old[i];
    return r;
  endfunction

  // 0 msip, 1 mtimecmp, 2 mtime, 3 unmapped
  function automatic int sel_of(input logic [63:0] a);
    logic [63:0] off;
    off = {a[63:3], 3'b000} - BASE;
    if (off == 64'h4000) return 1;
    if (off == 64'hBFF8) return 2;
`ifdef CLINT_MSIP_EN
    if (off == 64'h0) return 0;
`endif
    return 3;
  endfunction

  // One clock; mtip expectation comes from pre-edge model state.
  task automatic cyc(input bit wr, input int tgt, input logic [63:0] wd, input logic [7:0] wm);
    logic em [2];
    for (int d = 0; d < 2; d++) em[d] = (mt(d, k) >= cmp_m[d]);
    if (wr) begin
      if (tgt == 0 && wm[0]) msip_m = wd[0];
      for (int d = 0; d < 2; d++) begin
        if (tgt == 1) cmp_m[d] = merge(cmp_m[d], wd, wm);
        if (tgt == 2) begin
          base_val[d]   = merge(mt(d, k), wd, wm);
          base_ticks[d] = (k + 1) / div_of(d);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mtip%0d", d), 64'(mtip[d]), 64'(em[d]));
      chk($sformatf("msip%0d", d), 64'(msip[d]), 64'(msip_m));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, '0, '0);
  endtask

  task automatic req(input bit wen, input logic [63:0] addr, input logic [63:0] wd,
                     input logic [7:0] wm, input int hold);
    int          tgt;
    logic [63:0] er [2];
    logic        ee;
    tgt = sel_of(addr);
    ee  = (tgt == 3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("req_ready_idle%0d", d), 64'(req_ready[d]), 64'd1);
      er[d] = '0;
      if (!wen && tgt == 0) er[d] = {63'b0, msip_m};
      if (!wen && tgt == 1) er[d] = cmp_m[d];
      if (!wen && tgt == 2) er[d] = mt(d, k);
    end
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wd; req_wmask = wm; rsp_ready = 1'b0;
    cyc(wen && tgt != 3, tgt, wd, wm);
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) idle(1);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rsp_valid%0d", d), 64'(rsp_valid[d]), 64'd1);
        chk($sformatf("rsp_rdata%0d", d), rsp_rdata[d], er[d]);
        chk($sformatf("rsp_err%0d", d), 64'(rsp_err[d]), 64'(ee));
        chk($sformatf("req_ready_busy%0d", d), 64'(req_ready[d]), 64'd0);
      end
    end
    rsp_ready = 1'b1;
    idle(1);
    rsp_ready = 1'b0;
    for (int d = 0; d < 2; d++)
      chk($sformatf("rsp_valid_done%0d", d), 64'(rsp_valid[d]), 64'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, wd;
    logic [7:0]  wm;
    int          op;

    for (int d = 0; d < 2; d++) begin
      base_val[d] = '0; base_ticks[d] = 0; cmp_m[d] = '1;
    end
    msip_m = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rsp_valid%0d", d), 64'(rsp_valid[d]), 64'd0);
      chk($sformatf("rst_req_ready%0d", d), 64'(req_ready[d]), 64'd1);
      chk($sformatf("rst_rdata%0d", d), rsp_rdata[d], 64'd0);
      chk($sformatf("rst_err%0d", d), 64'(rsp_err[d]), 64'd0);
      chk($sformatf("rst_mtip%0d", d), 64'(mtip[d]), 64'd0);
      chk($sformatf("rst_msip%0d", d), 64'(msip[d]), 64'd0);
    end
    rst = 1'b0;

    // mtime starts at 0, then advances at each instance's own rate
    req(1'b0, BASE + 64'hBFF8, '0, '0, 0);
    idle(40);
    req(1'b0, BASE + 64'hBFF8, '0, '0, 0);

    // mtip rises once mtime reaches 20, falls when mtimecmp goes to all-ones
    req(1'b1, BASE + 64'hBFF8, 64'd0, 8'hFF, 0);
    req(1'b1, BASE + 64'h4000, 64'd20, 8'hFF, 0);
    idle(30);
    req(1'b1, BASE + 64'h4000, '1, 8'hFF, 0);
    idle(3);

    // partial byte write over a known value
    req(1'b1, BASE + 64'hBFF8, 64'hAAAA_AAAA_0000_0000, 8'hFF, 0);
    req(1'b1, BASE + 64'hBFF8, 64'h1111_1111_2222_2222, 8'h0F, 0);
    req(1'b0, BASE + 64'hBFF8, '0, '0, 0);

    // wrap of mtime across all-ones with mtimecmp = 5
    req(1'b1, BASE + 64'h4000, 64'd5, 8'hFF, 0);
    req(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
    idle(12);
    req(1'b0, BASE + 64'hBFF8, '0, '0, 0);

    // unmapped read held for 5 cycles; low address bits ignored
    req(1'b0, BASE + 64'h100, '0, '0, 5);
    req(1'b0, BASE + 64'h4005, '0, '0, 2);

    // msip write/read (unmapped when the feature is absent)
    req(1'b1, BASE, 64'd1, 8'h01, 0);
    req(1'b0, BASE + 64'h3, '0, '0, 1);
    req(1'b1, BASE, 64'd0, 8'hFF, 0);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      wd = {$urandom, $urandom};
      wm = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      a  = BASE + 64'($urandom_range(0, 7));
      case (op)
        0, 1: a = a + 64'hBFF8;
        2, 3: a = a + 64'h4000;
        4:    a = a + 64'h0;
        5:    a = a + 64'h100 + 64'(8 * $urandom_range(0, 255));
        6:    a = {$urandom, $urandom};
        7: begin
          a  = a + 64'h4000;
          wd = mt(1, k) + 64'($urandom_range(0, 12));
          wm = 8'hFF;
        end
        8: begin
          a  = a + 64'hBFF8;
          wd = cmp_m[1] - 64'($urandom_range(0, 6));
          wm = 8'hFF;
        end
        default: a = a + 64'hBFF8;
      endcase
      req(1'($urandom_range(0, 1)), a, wd, wm, $urandom_range(0, 2));
      idle($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_top.md
# clint_top

Core-local interruptor for the single-hart core. Holds the 64-bit `mtime` and `mtimecmp` registers, plus an optional `msip` register, behind a memory-mapped valid/ready port driven by the load/store unit. Drives `clint_mtip` (and `clint_msip`) into the CSR unit's interrupt inputs. It is the timer source for machine-timer interrupts.

## Interface
Parameters:
- `BASE_ADDR`, default `64'h0200_0000`, base of the CLINT region.
- `TICK_DIV`, default 1, clock cycles per `mtime` increment; legal range 1..65535.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_addr` in 64: byte address; bits [2:0] are ignored.
- `req_wdata` in 64: write data.
- `req_wmask` in 8: byte write enables.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid`.
- `rsp_rdata` out 64: read data; 0 for writes.
- `rsp_err` out 1: the address was outside the three mapped registers.
- `clint_mtip` out 1: timer interrupt pending.
- `clint_msip` out 1: software interrupt pending.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - `msip` at `0x0000`, bit 0 only; other bits read as 0.
  - `mtimecmp` at `0x4000`.
  - `mtime` at `0xBFF8`.
- Two-state FSM:
  - IDLE: `req_ready`=1. On accept, capture `rsp_rdata` and `rsp_err`, perform the write if any, then go to RESP.
  - RESP: `req_ready`=0 and `rsp_valid`=1. Go back to IDLE on `rsp_ready`.
- Writes:
  - Merged per byte: `new = (old & ~M) | (wdata & M)`, where M expands `req_wmask` to 64 bits.
  - A write to an unmapped address is dropped and sets `rsp_err`=1. A read of an unmapped address returns 0 with `rsp_err`=1.
- Reads return the register value before the same-cycle tick.
- Prescaler `tick_cnt`:
  - Counts 0..`TICK_DIV`-1. The tick asserts when `tick_cnt`==`TICK_DIV`-1, then `tick_cnt` wraps to 0.
  - On a tick, `mtime` increments by 1, unsigned. `mtime` wraps from all-ones to 0.
- Simultaneous tick and write to `mtime`: the write wins and that tick's increment is lost. The prescaler keeps running regardless.
- `clint_mtip` is registered as `mtime >= mtimecmp` (unsigned), using the register values at the start of the cycle.
- `clint_msip` is a direct copy of `msip[0]`.
- Reset values:
  - `mtime`=0, `mtimecmp`=all-ones, `msip`=0, `tick_cnt`=0.
  - FSM=IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `clint_mtip`=0, `clint_msip`=0.
- Reset asserted in RESP drops the pending response without a handshake.

## Timing
- Accept at edge N; `rsp_valid` is high from cycle N+1 until the `rsp_ready` handshake.
- Back-to-back throughput: one request per 2 cycles while `rsp_ready` is held at 1.
- A write to `mtimecmp` or `mtime` at edge N is reflected in `clint_mtip` after edge N+1.
- `rsp_rdata` and `rsp_err` stay stable while `rsp_valid`=1 and `rsp_ready`=0.

## Configuration
- `CLINT_MSIP_EN` defined: the `msip` register exists as described above.
- Not defined:
  - No `msip` flop; offset `0x0000` becomes unmapped (`rsp_err`=1).
  - `clint_msip` is tied to 0.

## Structure
- Shared package/defines (`defines.v`):
  - `CLINT_BASE`, `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`.
  - Reuse of `DATA_BUS`/`DATA_BUS_SIZE`.
- One sub-module, `clint_timer`, containing the prescaler, `mtime`, `mtimecmp` and the `clint_mtip` flop with its write ports.
- The top level holds the FSM, address decode, and response registers.

## Test plan
- Reset with `TICK_DIV`=4 → `mtime` reads 0. After 40 cycles a read returns 10, allowing ±1 for the read latency. `clint_mtip`=0 throughout.
- Write `mtimecmp`=20, with `TICK_DIV`=1 and `mtime` reset to 0 → `clint_mtip` rises exactly on the cycle after `mtime` reaches 20. It falls one cycle after `mtimecmp` is written to `0xFFFF_FFFF_FFFF_FFFF`.
- Write `mtime` with `wmask`=`8'h0F` and data `64'h1111_1111_2222_2222` over the old value `64'hAAAA_AAAA_0000_0000` → reads back `AAAA_AAAA_2222_222x`, where x reflects ticks after the write.
- Write `mtime`=`64'hFFFF_FFFF_FFFF_FFFE`, `TICK_DIV`=1 → reads pass 0 after the wrap. With `mtimecmp`=5, `clint_mtip` goes 1→0 across the wrap, then back to 1 at 5.
- Hold `rsp_ready`=0 for 5 cycles after a read of `BASE+0x100` → `rsp_valid`, `rsp_err`=1 and `rsp_rdata`=0 all stable, and `req_ready`=0 throughout.
- With `CLINT_MSIP_EN`: write 1 to `msip` → `clint_msip`=1 the next cycle. Without the macro, the same write gives `rsp_err`=1 and `clint_msip` stays 0.
